// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction ROM and the IF/ID pipeline register.
// A one-cycle BOOT state follows reset before sequential fetching starts.
module fetch_unit #(
  parameter int unsigned     WIDTH     = 32,
  parameter int unsigned     ADDR_BITS = 6,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_branch,
  input  logic             pc_source,
  input  logic             id_ready,
  output logic             if_valid,
  output logic [WIDTH-1:0] instruction,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_next,
  output logic [15:0]      fetch_count
);

  typedef enum logic {StBoot, StRun} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     pc_q;
  logic [ADDR_BITS-1:0] rom_idx;
  logic [WIDTH-1:0]     rom_data;
  logic                 accept;
  logic                 handshake;
  logic                 unused_branch_lsbs;

  // Word-aligned target; the byte-offset bits of the redirect address are dropped.
  assign unused_branch_lsbs = ^pc_branch[1:0];

  assign rom_idx = pc_q[ADDR_BITS+1:2];

  // Fixed program image: word i holds 0x1000 + i.
  assign rom_data = WIDTH'(32'h1000) + WIDTH'(rom_idx);

  assign accept    = !if_valid || id_ready;
  assign handshake = if_valid && id_ready;
  assign pc_next   = pc_out + WIDTH'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      if_valid    <= 1'b0;
      instruction <= '0;
      pc_out      <= '0;
      fetch_count <= '0;
    end else begin
      case (state_q)
        StBoot: state_q <= StRun;
        StRun: begin
          // A redirect does not cancel the handover of the currently presented instruction.
          if (handshake) begin
            fetch_count <= fetch_count + 16'd1;
          end
          if (pc_source) begin
            pc_q     <= {pc_branch[WIDTH-1:2], 2'b00};
            if_valid <= 1'b0;
          end else if (accept) begin
            instruction <= rom_data;
            pc_out      <= pc_q;
            if_valid    <= 1'b1;
            pc_q        <= pc_q + WIDTH'(4);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default parameters, ROM[i] = 0x1000 + i).
// Each comparison packs {if_valid, instruction, pc_out, pc_next, fetch_count}.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_branch;
  logic        pc_source;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_next;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [112:0] obs;
  logic [112:0] exp_v;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc_branch  (pc_branch),
    .pc_source  (pc_source),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .instruction(instruction),
    .pc_out     (pc_out),
    .pc_next    (pc_next),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign obs = {if_valid, instruction, pc_out, pc_next, fetch_count};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; pc_source = 1'b0; pc_branch = '0; id_ready = 1'b1;
    step();
    exp_v = {1'b0, 32'h0, 32'h0, 32'h4, 16'h0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_sequential();
    reset = 1'b1;
    step();
    exp_v = {1'b0, 32'h0, 32'h0, 32'h4, 16'h0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL boot_edge: got %h want %h", obs, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = {1'b1, 32'h1000 + 32'(i), 32'(4 * i), 32'(4 * i + 4), 16'(i)};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL seq_fetch_%0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = {1'b1, 32'h1002, 32'h8, 32'hC, 16'd2};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp_v);
      end
    end
    id_ready = 1'b1;
    step();
    exp_v = {1'b1, 32'h1003, 32'hC, 32'h10, 16'd3};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL stall_release: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_redirect();
    pc_source = 1'b1; pc_branch = 32'h2B; id_ready = 1'b0;
    step();
    exp_v = {1'b0, 32'h1003, 32'hC, 32'h10, 16'd3};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL redirect_squash: got %h want %h", obs, exp_v);
    end
    pc_source = 1'b0;
    step();
    exp_v = {1'b1, 32'h100A, 32'h28, 32'h2C, 16'd3};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL redirect_target: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_rom_wrap();
    // Redirect coinciding with a handshake still counts the handover.
    id_ready = 1'b1; pc_source = 1'b1; pc_branch = 32'hFC;
    step();
    exp_v = {1'b0, 32'h100A, 32'h28, 32'h2C, 16'd4};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL redirect_handshake: got %h want %h", obs, exp_v);
    end
    pc_source = 1'b0;
    step();
    exp_v = {1'b1, 32'h103F, 32'hFC, 32'h100, 16'd4};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL rom_last_word: got %h want %h", obs, exp_v);
    end
    step();
    exp_v = {1'b1, 32'h1000, 32'h100, 32'h104, 16'd5};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL rom_index_wrap: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_pc_wrap();
    pc_source = 1'b1; pc_branch = 32'hFFFF_FFFE;
    step();
    pc_source = 1'b0;
    step();
    exp_v = {1'b1, 32'h103F, 32'hFFFF_FFFC, 32'h0, 16'd6};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL pc_top_fetch: got %h want %h", obs, exp_v);
    end
    step();
    exp_v = {1'b1, 32'h1000, 32'h0, 32'h4, 16'd7};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL pc_wrap_zero: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_async_reset_boot();
    // Assert reset between edges: state must clear with no clock edge.
    #2;
    reset = 1'b0;
    #1;
    exp_v = {1'b0, 32'h0, 32'h0, 32'h4, 16'd0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", obs, exp_v);
    end
    step();
    reset = 1'b1; pc_source = 1'b1; pc_branch = 32'h40; id_ready = 1'b1;
    step();
    pc_source = 1'b0;
    exp_v = {1'b0, 32'h0, 32'h0, 32'h4, 16'd0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL boot_ignores_redirect: got %h want %h", obs, exp_v);
    end
    step();
    exp_v = {1'b1, 32'h1000, 32'h0, 32'h4, 16'd0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL boot_first_fetch: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_counter_wrap();
    // First fetch already presented with count 0; every further edge is a handshake.
    repeat (65535) step();
    n_checks++;
    if (fetch_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL count_max: got %h want ffff", fetch_count);
    end
    step();
    n_checks++;
    if (fetch_count !== 16'h0000) begin
      n_fail++; $display("FAIL count_wrap: got %h want 0000", fetch_count);
    end
    step();
    n_checks++;
    if (fetch_count !== 16'h0001) begin
      n_fail++; $display("FAIL count_65537: got %h want 0001", fetch_count);
    end
    n_checks++;
    if (if_valid !== 1'b1) begin
      n_fail++; $display("FAIL stream_valid: got %b want 1", if_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_rom_wrap();
    test_pc_wrap();
    test_async_reset_boot();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
